egg_timer_datapath: RTL and testbench
=====================================

Name: egg_timer_datapath

Overview:
- Countdown datapath directly downstream of the egg-timer controller FSM.
- Consumes the controller's 3-bit state code and the setting switches, and holds the MM:SS value as four BCD digits.
- Prescales clk to a 1 s tick and counts down to 00:00.
- Drives the 7-seg decoders with digits plus a blank strobe, and raises done at expiry.

Parameters:
- TICK_DIV, 50000000: clk cycles per countdown tick (1 s at 50 MHz); benches use a small value (e.g. 4); legal range 2..2^26.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous and active-high.
- state  input  3  controller state code: RESET=100, SET_SEC=000, SET_MIN=001, SETTING_MIN=111, READY=011, TIMER=010, FLASH_ON=101, FLASH_OFF=110.
- sw  input  8  setting value, two BCD digits: [7:4] tens, [3:0] ones; already synchronized upstream.
- min_bcd  output  8  minutes, BCD [7:4] tens, [3:0] ones.
- sec_bcd  output  8  seconds, BCD [7:4] tens, [3:0] ones.
- tick  output  1  one-cycle pulse on each prescaler wrap while counting.
- done  output  1  countdown reached 00:00; sticky.
- blank  output  1  display blank request, for flash effect.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered, with 1-cycle latency from state/sw.
- rst=1 at a posedge forces the following, overriding everything:
  - min_bcd=00, sec_bcd=00
  - prescaler=0
  - tick=0, done=0, blank=0
- Per-state action at each posedge (rst=0):
  - RESET: clear min, sec, prescaler, done (same values as rst).
  - SET_SEC: sec_bcd <= sw if tens<=5 and ones<=9, else 0x59; done<=0; prescaler held 0.
  - SET_MIN: min_bcd <= sw if tens<=9 and ones<=9, else 0x99; done<=0; prescaler held 0.
  - SETTING_MIN, READY: hold min/sec/done; prescaler held 0.
  - TIMER, FLASH_ON, FLASH_OFF are the counting states. The countdown continues through the flash states, because the controller leaves TIMER after one cycle.
- Prescaler (counting states only):
  - Increments 0..TICK_DIV-1.
  - On the cycle it equals TICK_DIV-1 it wraps to 0 and tick=1 for that one cycle; tick=0 otherwise.
  - Any non-counting state zeroes it.
  - First tick therefore lands exactly TICK_DIV cycles after entry into TIMER.
- Decrement on tick, BCD with borrow:
  - sec ones 0 -> 9 with borrow; sec tens 0 -> 5 with borrow into minutes.
  - min ones 0 -> 9 with borrow; min tens decrements.
  - If value is 00:00 at a tick: no change (no wrap to 99:59), done<=1.
  - If a decrement produces 00:00: done<=1 in the same cycle the value updates.
- done is sticky. It clears only on rst, RESET, SET_SEC or SET_MIN.
- blank = 1 iff registered (state==FLASH_OFF && done); otherwise 0. While running, flash states do not blank.
- Simultaneous events: a state change out of the counting states on the same cycle as a wrap suppresses that tick and decrement, because the new state governs. rst beats every state.
- Reset mid-count returns all outputs to zero on the next edge; no residual prescaler phase survives.
- All 8 state codes are defined; there is no illegal-state handling.

Test Plan:
- Run rst=1 for 2 cycles, then state=RESET → min_bcd=0x00, sec_bcd=0x00, done=0, blank=0, tick=0.
- TICK_DIV=4; SET_SEC with sw=0x05, then SET_MIN with sw=0x01, READY, then TIMER→FLASH_ON/OFF alternating:
  - tick every 4 cycles.
  - values step 01:05, 01:04 … 01:00, 00:59, 00:58.
  - borrow crosses the minute boundary correctly.
- Set 00:02 and count →
  - 00:01, then 00:00 with done=1 on the same edge.
  - further ticks hold 00:00.
  - blank=1 exactly on cycles following FLASH_OFF.
- SET_SEC with sw=0x7A → sec_bcd=0x59; SET_MIN with sw=0xF3 → min_bcd=0x99; sw=0x45 in SET_SEC → sec_bcd=0x45.
- Mid-count (e.g. 00:37, prescaler=2), apply rst=1 one cycle → all zero next edge. Re-entering TIMER gives the first tick after a full 4 cycles.
- Leave TIMER for READY on the exact wrap cycle → no tick, no decrement, value held, prescaler=0.

Source files
------------

// File: rtl/egg_timer_datapath.sv
// Egg-timer countdown datapath: holds MM:SS as four BCD digits, prescales clk to a
// countdown tick, decrements to 00:00 and drives done/blank for the display path.
module egg_timer_datapath #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic [7:0] sw,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       tick,
  output logic       done,
  output logic       blank
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StSetSec     = 3'b000,
    StSetMin     = 3'b001,
    StTimer      = 3'b010,
    StReady      = 3'b011,
    StReset      = 3'b100,
    StFlashOn    = 3'b101,
    StFlashOff   = 3'b110,
    StSettingMin = 3'b111
  } state_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;
  logic          blank_q, blank_d;
  logic [15:0]   dec_val;

  // One BCD step down of {min tens, min ones, sec tens, sec ones}, seconds borrow at 0 -> 5.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    logic       borrow;
    {mt, mo, st, so} = v;
    borrow = (so == 4'd0);
    so     = borrow ? 4'd9 : so - 4'd1;
    if (borrow) begin
      borrow = (st == 4'd0);
      st     = borrow ? 4'd5 : st - 4'd1;
    end
    if (borrow) begin
      borrow = (mo == 4'd0);
      mo     = borrow ? 4'd9 : mo - 4'd1;
    end
    if (borrow) begin
      mt = mt - 4'd1;
    end
    return {mt, mo, st, so};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input logic [3:0] tens_max);
    return (v[7:4] <= tens_max) && (v[3:0] <= 4'd9);
  endfunction

  assign dec_val = bcd_dec({min_q, sec_q});

  always_comb begin
    min_d   = min_q;
    sec_d   = sec_q;
    done_d  = done_q;
    presc_d = '0;
    tick_d  = 1'b0;
    unique case (state_e'(state))
      StReset: begin
        min_d  = 8'h00;
        sec_d  = 8'h00;
        done_d = 1'b0;
      end
      StSetSec: begin
        sec_d  = bcd_ok(sw, 4'd5) ? sw : 8'h59;
        done_d = 1'b0;
      end
      StSetMin: begin
        min_d  = bcd_ok(sw, 4'd9) ? sw : 8'h99;
        done_d = 1'b0;
      end
      StSettingMin, StReady: begin
      end
      StTimer, StFlashOn, StFlashOff: begin
        if (presc_q == PrescMax) begin
          tick_d = 1'b1;
          // At 00:00 the value is held rather than wrapping to 99:59.
          if ({min_q, sec_q} == 16'h0000) begin
            done_d = 1'b1;
          end else begin
            {min_d, sec_d} = dec_val;
            if (dec_val == 16'h0000) begin
              done_d = 1'b1;
            end
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    endcase
    blank_d = (state_e'(state) == StFlashOff) && done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      blank_q <= blank_d;
    end
  end

  assign min_bcd = min_q;
  assign sec_bcd = sec_q;
  assign tick    = tick_q;
  assign done    = done_q;
  assign blank   = blank_q;

endmodule

// File: tb/tb_egg_timer_datapath.sv
// Bench for egg_timer_datapath: table of setting vectors, a seconds-based reference model
// feeding a scoreboard queue, and hand sequences for countdown corner cases.
module tb_egg_timer_datapath;

  localparam int TD = 4;
  localparam logic [2:0] S_SEC = 3'b000, S_MIN = 3'b001, S_TIMER = 3'b010, S_READY = 3'b011,
                         S_RESET = 3'b100, S_FON = 3'b101, S_FOFF = 3'b110, S_SMIN = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state = S_RESET;
  logic [7:0] sw = 8'h00;
  logic [7:0] min_bcd, sec_bcd;
  logic       tick, done, blank;

  egg_timer_datapath #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .state(state), .sw(sw),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .tick(tick), .done(done), .blank(blank)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] mn;
    logic [7:0] sc;
    logic       tk;
    logic       dn;
    logic       bl;
  } exp_t;

  typedef struct {
    logic [2:0] st;
    logic [7:0] sw;
    exp_t       e;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  // Reference model kept as total seconds, independent of BCD digit borrow rules.
  logic [7:0] m_min = 8'h00, m_sec = 8'h00;
  int         m_presc = 0;
  logic       m_tick = 1'b0, m_done = 1'b0, m_blank = 1'b0;

  function automatic int b2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] i2b(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic model_edge(input logic r, input logic [2:0] st, input logic [7:0] s);
    int tot;
    m_tick = 1'b0;
    if (r) begin
      m_min = 8'h00; m_sec = 8'h00; m_presc = 0; m_done = 1'b0;
    end else begin
      case (st)
        S_RESET: begin m_min = 8'h00; m_sec = 8'h00; m_presc = 0; m_done = 1'b0; end
        S_SEC: begin
          m_sec = (s[7:4] <= 4'd5 && s[3:0] <= 4'd9) ? s : 8'h59;
          m_done = 1'b0; m_presc = 0;
        end
        S_MIN: begin
          m_min = (s[7:4] <= 4'd9 && s[3:0] <= 4'd9) ? s : 8'h99;
          m_done = 1'b0; m_presc = 0;
        end
        S_SMIN, S_READY: m_presc = 0;
        default: begin
          if (m_presc == TD - 1) begin
            m_presc = 0;
            m_tick = 1'b1;
            tot = b2i(m_min) * 60 + b2i(m_sec);
            if (tot > 0) tot = tot - 1;
            if (tot == 0) m_done = 1'b1;
            m_min = i2b(tot / 60);
            m_sec = i2b(tot % 60);
          end else begin
            m_presc = m_presc + 1;
          end
        end
      endcase
    end
    m_blank = !r && (st == S_FOFF) && m_done;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] st, input logic [7:0] s);
    exp_t e, g;
    @(negedge clk);
    rst = r; state = st; sw = s;
    model_edge(r, st, s);
    sb.push_back({m_min, m_sec, m_tick, m_done, m_blank});
    @(posedge clk);
    #1;
    g = {min_bcd, sec_bcd, tick, done, blank};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: empty queue, got=%h", g);
    end else begin
      e = sb.pop_front();
      if (g !== e) begin
        bad++;
        $display("FAIL step st=%b sw=%h: got min=%h sec=%h tick=%b done=%b blank=%b expected min=%h sec=%h tick=%b done=%b blank=%b",
                 st, s, g.mn, g.sc, g.tk, g.dn, g.bl, e.mn, e.sc, e.tk, e.dn, e.bl);
      end
    end
  endtask

  function automatic logic [2:0] cnt_state(input int i);
    if (i == 0) return S_TIMER;
    return (i % 2 == 1) ? S_FON : S_FOFF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[12];
    int   first_tick;

    tbl[0]  = '{S_RESET, 8'h00, '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0}};
    tbl[1]  = '{S_SEC,   8'h7A, '{8'h00, 8'h59, 1'b0, 1'b0, 1'b0}};
    tbl[2]  = '{S_MIN,   8'hF3, '{8'h99, 8'h59, 1'b0, 1'b0, 1'b0}};
    tbl[3]  = '{S_SEC,   8'h45, '{8'h99, 8'h45, 1'b0, 1'b0, 1'b0}};
    tbl[4]  = '{S_MIN,   8'h9A, '{8'h99, 8'h45, 1'b0, 1'b0, 1'b0}};
    tbl[5]  = '{S_MIN,   8'h23, '{8'h23, 8'h45, 1'b0, 1'b0, 1'b0}};
    tbl[6]  = '{S_SEC,   8'h60, '{8'h23, 8'h59, 1'b0, 1'b0, 1'b0}};
    tbl[7]  = '{S_SMIN,  8'h11, '{8'h23, 8'h59, 1'b0, 1'b0, 1'b0}};
    tbl[8]  = '{S_READY, 8'h77, '{8'h23, 8'h59, 1'b0, 1'b0, 1'b0}};
    tbl[9]  = '{S_SEC,   8'h09, '{8'h23, 8'h09, 1'b0, 1'b0, 1'b0}};
    tbl[10] = '{S_MIN,   8'h90, '{8'h90, 8'h09, 1'b0, 1'b0, 1'b0}};
    tbl[11] = '{S_RESET, 8'h55, '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0}};

    // Reset
    step(1'b1, S_RESET, 8'h00);
    step(1'b1, S_RESET, 8'h00);
    check("reset_outputs", {5'd0, min_bcd, sec_bcd, tick, done, blank}, 32'd0);

    // Setting vectors
    foreach (tbl[i]) begin
      step(1'b0, tbl[i].st, tbl[i].sw);
      check($sformatf("table[%0d]", i), {5'd0, min_bcd, sec_bcd, tick, done, blank},
            {5'd0, tbl[i].e});
    end

    // 01:05 countdown across the minute boundary
    step(1'b0, S_SEC, 8'h05);
    step(1'b0, S_MIN, 8'h01);
    step(1'b0, S_READY, 8'h00);
    first_tick = -1;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, cnt_state(i), 8'h00);
      if (tick && first_tick < 0) first_tick = i;
      if (i == 23) check("borrow_0059", {16'd0, min_bcd, sec_bcd}, 32'h0000_0059);
    end
    check("first_tick_idx", first_tick, 32'd3);
    check("after_10_ticks", {16'd0, min_bcd, sec_bcd}, 32'h0000_0055);

    // 00:02 to expiry, hold at 00:00, blank on FLASH_OFF only
    step(1'b0, S_SEC, 8'h02);
    step(1'b0, S_MIN, 8'h00);
    step(1'b0, S_READY, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, cnt_state(i), 8'h00);
      if (i == 7) check("expiry_edge", {15'd0, done, min_bcd, sec_bcd}, 32'h0001_0000);
      if (i == 8) check("blank_on_off", {31'd0, blank}, 32'd1);
      if (i == 9) check("blank_on_on", {31'd0, blank}, 32'd0);
    end
    check("held_00_00", {15'd0, done, min_bcd, sec_bcd}, 32'h0001_0000);

    // rst mid-count, then a full prescale period on re-entry
    step(1'b0, S_SEC, 8'h37);
    step(1'b0, S_MIN, 8'h00);
    step(1'b0, S_READY, 8'h00);
    step(1'b0, S_TIMER, 8'h00);
    step(1'b0, S_FON, 8'h00);
    step(1'b1, S_FOFF, 8'h00);
    check("rst_midcount", {5'd0, min_bcd, sec_bcd, tick, done, blank}, 32'd0);
    step(1'b0, S_SEC, 8'h37);
    step(1'b0, S_READY, 8'h00);
    first_tick = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, cnt_state(i), 8'h00);
      if (tick && first_tick < 0) first_tick = i;
    end
    check("reentry_tick_idx", first_tick, 32'd3);

    // Leaving the counting states on the wrap cycle suppresses the tick
    step(1'b0, S_SEC, 8'h10);
    step(1'b0, S_READY, 8'h00);
    step(1'b0, S_TIMER, 8'h00);
    step(1'b0, S_FON, 8'h00);
    step(1'b0, S_FOFF, 8'h00);
    step(1'b0, S_READY, 8'h00);
    check("wrap_suppressed", {15'd0, tick, min_bcd, sec_bcd}, 32'h0000_0010);
    for (int i = 0; i < 4; i++) step(1'b0, cnt_state(i), 8'h00);
    check("resume_full_period", {15'd0, tick, min_bcd, sec_bcd}, 32'h0001_0009);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
